// File: rtl/sobel_stream_3x3.sv
// rtl/sobel_stream_3x3.sv - streaming 3x3 Sobel gradient engine (Gx, Gy, |Gx|+|Gy|, bypass)
module sobel_stream_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int OUT_W  = DATA_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [OUT_W-1:0]  out_data
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int G  = DATA_W + 3;
  localparam int SW = DATA_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          active;
  logic [1:0]    mode_q;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // A beat carrying in_sof always restarts the frame at (0,0), even mid-frame.
  always_comb begin
    accept  = in_valid && (in_sof || active);
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      active <= 1'b0;
      mode_q <= 2'd0;
    end else if (accept) begin
      if (in_sof) begin
        active <= 1'b1;
        mode_q <= cfg_mode;
      end
      if (cur_col == COL_LAST) begin
        col <= '0;
        if (cur_row == ROW_LAST) begin
          row    <= '0;
          active <= 1'b0;
        end else begin
          row <= cur_row + 1'b1;
        end
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] win_l [3];
  logic [DATA_W-1:0] win_m [3];
  logic [DATA_W-1:0] top, mid, bot;

  always_comb begin
    top = lb2[cur_col];
    mid = lb1[cur_col];
    bot = in_data;
  end

  // Storage only; stale contents are masked by the row/col window qualifier.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= mid;
      lb1[cur_col] <= in_data;
      win_l[0]     <= win_m[0];
      win_l[1]     <= win_m[1];
      win_l[2]     <= win_m[2];
      win_m[0]     <= top;
      win_m[1]     <= mid;
      win_m[2]     <= bot;
    end
  end

  logic          win_ok;
  logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

  always_comb begin
    win_ok = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    gx_pos = {2'b00, top} + {1'b0, mid, 1'b0} + {2'b00, bot};
    gx_neg = {2'b00, win_l[0]} + {1'b0, win_l[1], 1'b0} + {2'b00, win_l[2]};
    gy_pos = {2'b00, win_l[2]} + {1'b0, win_m[2], 1'b0} + {2'b00, bot};
    gy_neg = {2'b00, win_l[0]} + {1'b0, win_m[0], 1'b0} + {2'b00, top};
  end

  logic              s1_valid, s1_sof, s1_eol, s1_eof;
  logic [SW-1:0]     s1_gxp, s1_gxn, s1_gyp, s1_gyn;
  logic [DATA_W-1:0] s1_ctr;
  logic [1:0]        s1_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_gxp   <= '0;
      s1_gxn   <= '0;
      s1_gyp   <= '0;
      s1_gyn   <= '0;
      s1_ctr   <= '0;
      s1_mode  <= 2'd0;
    end else begin
      s1_valid <= win_ok;
      s1_sof   <= win_ok && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
      s1_eol   <= win_ok && (cur_col == COL_LAST);
      s1_eof   <= win_ok && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      if (win_ok) begin
        s1_gxp  <= gx_pos;
        s1_gxn  <= gx_neg;
        s1_gyp  <= gy_pos;
        s1_gyn  <= gy_neg;
        s1_ctr  <= win_m[1];
        s1_mode <= mode_q;
      end
    end
  end

  logic signed [G-1:0] gx, gy;
  logic [G-1:0]        ax, ay;
  logic [OUT_W-1:0]    res;

  // Signed casts sign-extend Gx/Gy; magnitude and bypass zero-extend.
  always_comb begin
    gx = $signed({1'b0, s1_gxp}) - $signed({1'b0, s1_gxn});
    gy = $signed({1'b0, s1_gyp}) - $signed({1'b0, s1_gyn});
    ax = gx[G-1] ? -gx : gx;
    ay = gy[G-1] ? -gy : gy;
    case (s1_mode)
      2'd0:    res = OUT_W'(gx);
      2'd1:    res = OUT_W'(gy);
      2'd2:    res = OUT_W'(ax + ay);
      default: res = OUT_W'(s1_ctr);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sof   <= s1_valid && s1_sof;
      out_eol   <= s1_valid && s1_eol;
      out_eof   <= s1_valid && s1_eof;
      out_data  <= s1_valid ? res : '0;
    end
  end
endmodule

// File: doc/sobel_stream_3x3.md
Name: sobel_stream_3x3

Overview:
- Streaming 3x3 Sobel gradient engine for the binocular pipeline. It replaces the fixed, window-fed, unreset horizontal-only convolution with a raster-scan pixel stream.
- Internally it holds two line buffers and a 3x3 window. It computes Gx, Gy, |Gx|+|Gy| or bypass, selected per frame, for any pixel width and image size.
- It sits between each camera's grey-scale stage and the stereo matching cost stage; one instance runs per camera.

Parameters:
- DATA_W, 8, input pixel width (unsigned).
- IMG_W, 640, pixels per line (>=4).
- IMG_H, 480, lines per frame (>=3).
- OUT_W, DATA_W+3, output width; must be >= DATA_W+3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_mode  in  2  0=Gx, 1=Gy, 2=|Gx|+|Gy|, 3=bypass centre pixel.
- in_valid  in  1  input pixel valid; the block has no backpressure and accepts every valid beat.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_data  in  DATA_W  pixel, raster order.
- out_valid  out  1  output result valid.
- out_sof  out  1  first output of frame (centre pixel r=1, c=1).
- out_eol  out  1  last output of a line (c=IMG_W-2).
- out_eof  out  1  last output of frame (r=IMG_H-2, c=IMG_W-2).
- out_data  out  OUT_W  result; two's complement in modes 0/1, unsigned in modes 2/3.

Behaviour:
- Reset
  - When rst_n=0 at a clk edge, all outputs go to 0 and the pipeline valid bits clear.
  - Row and column counters go to 0 and the frame-active flag clears.
  - The latched mode goes to 0.
  - Line buffer contents are don't-care.
  - Reset mid-frame abandons that frame. Input is ignored until the next in_sof.
- Counters
  - col increments on each accepted pixel and wraps IMG_W-1 -> 0, at which point row increments.
  - A beat with in_valid&in_sof forces (row, col) = (0, 0) for that pixel, sets frame-active and latches cfg_mode. This applies mid-frame too (resync): partial-frame state is discarded and no outputs are produced until the new frame reaches row 2, col 2.
  - cfg_mode changes at any other time are ignored.
  - Pixels after (IMG_H-1, IMG_W-1) are dropped and frame-active clears until the next in_sof.
- Window
  - Two line buffers, each of depth IMG_W, hold rows r-1 and r-2.
  - A 3-column shift register forms the window over rows r-2..r.
  - The window is valid when row>=2 and col>=2. The window centre is (row-1, col-1).
  - Only interior pixels produce output: (IMG_W-2)*(IMG_H-2) outputs per frame. Border pixels produce no output beats.
- Kernels (p[i][j], i=row offset 0..2 top to bottom, j=column offset 0..2 left to right)
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - All sums are computed exactly in DATA_W+3 signed bits, with no overflow: max |G| = 4*(2^DATA_W-1).
  - Mode 2 = |Gx|+|Gy|. Max 8*(2^DATA_W-1) fits in DATA_W+3 unsigned bits, so no saturation.
  - Mode 3 = p11, zero-extended.
  - When OUT_W exceeds DATA_W+3, the result is sign-extended in modes 0/1 and zero-extended in modes 2/3.
- Latency and timing
  - Latency is fixed at 2 cycles: the accepted beat completing the window (pixel r+1, c+1) at cycle t gives out_valid at t+2.
  - Stage 1 registers the partial sums; stage 2 registers the final result.
  - Gaps in in_valid stall nothing. Each output is still produced exactly 2 cycles after its completing beat, and out_valid deasserts for gap cycles.
  - When out_valid=0, out_data, out_sof, out_eol and out_eof are 0.
- Simultaneous events
  - in_sof on the same beat as the last pixel of a frame: that beat is treated as the first pixel of the new frame. The old frame's last window does not complete and its out_eof is not emitted.
  - rst_n=0 overrides all other inputs.

Test Plan:
- IMG_W=8, IMG_H=6, constant 100, mode 0 -> 24 outputs all 0; out_sof on 1st, out_eol on every 6th, out_eof on 24th; each output 2 cycles after its completing beat.
- Horizontal ramp pixel=10*c: mode 0 -> all outputs 80; same frame in mode 1 -> all 0; mode 3 -> out_data=10*c for c=1..6.
- Vertical ramp pixel=10*r: mode 1 -> all 80; mode 2 -> all 80.
- Step edge (pixel=0 for c<4, 255 for c>=4, DATA_W=8): mode 0 -> 1020 at c=3 and c=4, 0 elsewhere. Inverted step -> -1020 (11'h404). Mode 2 -> 1020.
- 50% random in_valid gaps over random pixels -> output sequence identical to a gap-free run. cfg_mode toggled mid-frame -> no effect until next in_sof. in_sof at row 3 -> counters restart, first new out_sof after new row 2, col 2.
- rst_n=0 for 1 cycle mid-frame -> all outputs 0 on the following cycle, no further outputs until in_sof; next full frame matches the reference model.
